// File: rtl/gate_checker_pkg.sv
// Shared gate-select codes, FSM state encoding and select validation for the gate checker.
package gate_checker_pkg;

   localparam logic [2:0] GATE_AND  = 3'b000;
   localparam logic [2:0] GATE_OR   = 3'b001;
   localparam logic [2:0] GATE_NAND = 3'b010;
   localparam logic [2:0] GATE_NOR  = 3'b011;
   localparam logic [2:0] GATE_XOR  = 3'b100;
   localparam logic [2:0] GATE_XNOR = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_DONE
   } state_t;

   function automatic logic is_valid_sel(input logic [2:0] sel);
      return (sel <= GATE_XNOR);
   endfunction

endpackage

// File: rtl/multi_gate_checker_ref.sv
// Reference gate model: reduces the current sweep vector with the selected logic function.
module gate_ref_model
   import gate_checker_pkg::*;
#(
   parameter int N_IN = 4
) (
   input  logic [N_IN-1:0] vector,
   input  logic [2:0]      gate_sel,
   output logic            ref_bit
);

   always_comb begin
      ref_bit = 1'b0;
      case (gate_sel)
         GATE_AND:  ref_bit = &vector;
         GATE_OR:   ref_bit = |vector;
         GATE_NAND: ref_bit = ~(&vector);
         GATE_NOR:  ref_bit = ~(|vector);
         GATE_XOR:  ref_bit = ^vector;
         GATE_XNOR: ref_bit = ~(^vector);
         default:   ref_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_gate_checker.sv
// Exhaustive sweep tester for N_CH identical gates: holds each vector SETTLE_CYCLES cycles,
// compares sampled outputs against the reference model on the fly and reports pass/fail.
module multi_gate_checker
   import gate_checker_pkg::*;
#(
   parameter int N_IN          = 4,
   parameter int N_CH          = 2,
   parameter int SETTLE_CYCLES = 50000000,
   parameter int CNT_W         = 26
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 start,
   input  logic [2:0]           gate_sel,
   input  logic [N_CH-1:0]      op,
   output logic [N_CH*N_IN-1:0] drive,
   output logic                 busy,
   output logic                 done,
   output logic [N_CH-1:0]      pass_ch,
   output logic [N_CH-1:0]      fail_ch,
   output logic                 pass,
   output logic                 fail,
   output logic                 sel_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [N_IN-1:0]  VEC_LAST = '1;

   state_t            state;
   logic [2:0]        sel_lat;
   logic [N_IN-1:0]   vector;
   logic [N_IN-1:0]   vector_inc;
   logic [CNT_W-1:0]  counter;
   logic [N_CH-1:0]   mismatch;
   logic [N_CH-1:0]   mismatch_next;
   logic              ref_bit;
   logic              sample_edge;

   gate_ref_model #(.N_IN(N_IN)) u_ref (
      .vector   (vector),
      .gate_sel (sel_lat),
      .ref_bit  (ref_bit)
   );

   assign vector_inc    = vector + 1'b1;
   assign sample_edge   = (counter == CNT_LAST);
   assign mismatch_next = mismatch | (op ^ {N_CH{ref_bit}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         sel_lat  <= '0;
         vector   <= '0;
         counter  <= '0;
         mismatch <= '0;
         drive    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass_ch  <= '0;
         fail_ch  <= '0;
         pass     <= 1'b0;
         fail     <= 1'b0;
         sel_err  <= 1'b0;
      end else if (!enable) begin
         // Abort behaves exactly like reset, whatever the state.
         state    <= ST_IDLE;
         sel_lat  <= '0;
         vector   <= '0;
         counter  <= '0;
         mismatch <= '0;
         drive    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass_ch  <= '0;
         fail_ch  <= '0;
         pass     <= 1'b0;
         fail     <= 1'b0;
         sel_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  sel_lat  <= gate_sel;
                  vector   <= '0;
                  counter  <= '0;
                  mismatch <= '0;
                  drive    <= '0;
                  done     <= 1'b0;
                  pass_ch  <= '0;
                  fail_ch  <= '0;
                  pass     <= 1'b0;
                  fail     <= 1'b0;
                  sel_err  <= 1'b0;
                  if (is_valid_sel(gate_sel)) begin
                     busy  <= 1'b1;
                     state <= ST_SETTLE;
                  end else begin
                     // Unknown gate: report failure on every channel without sweeping.
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     sel_err <= 1'b1;
                     fail    <= 1'b1;
                     fail_ch <= '1;
                     state   <= ST_DONE;
                  end
               end
            end
            ST_SETTLE: begin
               if (sample_edge) begin
                  counter  <= '0;
                  mismatch <= mismatch_next;
                  if (vector == VEC_LAST) begin
                     state   <= ST_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     fail_ch <= mismatch_next;
                     pass_ch <= ~mismatch_next;
                     pass    <= ~(|mismatch_next);
                     fail    <= |mismatch_next;
                     drive   <= '0;
                  end else begin
                     vector <= vector_inc;
                     drive  <= {N_CH{vector_inc}};
                  end
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_gate_checker.sv
// Bench for multi_gate_checker: table of gate/fault scenarios run through a result scoreboard,
// plus hand sequences for abort, asynchronous reset and start-while-busy.
module tb_multi_gate_checker;

   localparam int N_IN   = 4;
   localparam int N_CH   = 2;
   localparam int SETTLE = 4;
   localparam int SWEEP  = (1 << N_IN) * SETTLE;

   typedef struct {
      logic [2:0] sel;
      int         mode;
      logic [1:0] pch;
      logic [1:0] fch;
      logic       ps;
      logic       fl;
      logic       se;
      int         lat;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 enable;
   logic                 start;
   logic [2:0]           gate_sel;
   logic [N_CH-1:0]      op;
   logic [N_CH*N_IN-1:0] drive;
   logic                 busy, done, pass, fail, sel_err;
   logic [N_CH-1:0]      pass_ch, fail_ch;

   logic [2:0] model_sel = 3'b000;
   int         mode = 0;
   int         n_cmp = 0;
   int         n_fail = 0;
   vec_t       sb[$];
   vec_t       tbl[9];

   always #5 clk = ~clk;

   multi_gate_checker #(
      .N_IN(N_IN), .N_CH(N_CH), .SETTLE_CYCLES(SETTLE), .CNT_W(3)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .start(start), .gate_sel(gate_sel),
      .op(op), .drive(drive), .busy(busy), .done(done), .pass_ch(pass_ch),
      .fail_ch(fail_ch), .pass(pass), .fail(fail), .sel_err(sel_err)
   );

   function automatic logic gate_fn(input logic [2:0] s, input logic [3:0] v);
      case (s)
         3'd0:    return v[0] & v[1] & v[2] & v[3];
         3'd1:    return v[0] | v[1] | v[2] | v[3];
         3'd2:    return !(v[0] & v[1] & v[2] & v[3]);
         3'd3:    return !(v[0] | v[1] | v[2] | v[3]);
         3'd4:    return v[0] ^ v[1] ^ v[2] ^ v[3];
         3'd5:    return !(v[0] ^ v[1] ^ v[2] ^ v[3]);
         default: return 1'b0;
      endcase
   endfunction

   // Socket model: good gates, optionally with a stuck or last-vector fault.
   always_comb begin
      op = '0;
      for (int c = 0; c < N_CH; c++) op[c] = gate_fn(model_sel, drive[c*N_IN +: N_IN]);
      if (mode == 1) op[1] = 1'b0;
      if (mode == 2 && drive[3:0] == 4'hF) op[0] = ~op[0];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {18'd0, busy, done, drive, pass_ch, fail_ch, pass, fail, sel_err};
   endfunction

   task automatic run_test(input vec_t v, input int extra_start);
      vec_t        e;
      int          lat;
      logic [3:0]  vv;
      model_sel = v.sel;
      mode      = v.mode;
      @(negedge clk);
      gate_sel = v.sel;
      start    = 1'b1;
      sb.push_back(v);
      @(negedge clk);
      start    = 1'b0;
      gate_sel = ~v.sel;
      lat = 0;
      if (v.lat != 0) begin
         check("start_drive", 32'(drive), 32'h0);
         check("start_busy", 32'(busy), 32'h1);
      end
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         start = (lat == extra_start);
         if (!done && lat % SETTLE == 0) begin
            vv = 4'(lat / SETTLE);
            check("sweep_drive", 32'(drive), 32'({vv, vv}));
         end
      end
      start = 1'b0;
      if (lat >= 200) check("done_timeout", 32'(lat), 32'(v.lat));
      e = sb.pop_front();
      check("latency", 32'(lat), 32'(e.lat));
      check("done", 32'(done), 32'h1);
      check("busy_end", 32'(busy), 32'h0);
      check("drive_end", 32'(drive), 32'h0);
      check("pass_ch", 32'(pass_ch), 32'(e.pch));
      check("fail_ch", 32'(fail_ch), 32'(e.fch));
      check("pass", 32'(pass), 32'(e.ps));
      check("fail", 32'(fail), 32'(e.fl));
      check("sel_err", 32'(sel_err), 32'(e.se));
   endtask

   initial begin
      tbl[0] = '{3'b000, 0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, SWEEP};
      tbl[1] = '{3'b010, 1, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0, SWEEP};
      tbl[2] = '{3'b100, 2, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, SWEEP};
      tbl[3] = '{3'b001, 0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, SWEEP};
      tbl[4] = '{3'b011, 0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, SWEEP};
      tbl[5] = '{3'b101, 0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, SWEEP};
      tbl[6] = '{3'b111, 0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 0};
      tbl[7] = '{3'b000, 1, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0, SWEEP};
      tbl[8] = '{3'b110, 0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 0};

      rst = 1'b1; enable = 1'b1; start = 1'b0; gate_sel = 3'b000;
      repeat (2) @(negedge clk);
      check("reset_outs", all_outs(), 32'h0);
      rst = 1'b0;

      foreach (tbl[i]) run_test(tbl[i], -1);

      // Abort with enable low while vector 0111 is on the pins.
      model_sel = 3'b000; mode = 0;
      @(negedge clk);
      gate_sel = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7 * SETTLE) @(negedge clk);
      check("abort_vec", 32'(drive), 32'h77);
      enable = 1'b0;
      @(negedge clk);
      check("abort_outs", all_outs(), 32'h0);
      enable = 1'b1;
      run_test(tbl[0], -1);

      // Asynchronous reset between edges, start ignored while held.
      model_sel = 3'b100; mode = 0;
      @(negedge clk);
      gate_sel = 3'b100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("async_rst_outs", all_outs(), 32'h0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_rst", all_outs(), 32'h0);
      rst = 1'b0;

      // Start pulse mid-sweep must not disturb timing or results.
      run_test(tbl[2], 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
